// File: rtl/ccfilt_sequencer.sv
// Frame sequencer for the ccfilt decimation datapath: times decimation periods,
// pulses the integrator snapshot and frames the DSR_LEN-word readout.
module ccfilt_sequencer #(
  parameter int DSR_LEN = 12,
  parameter int PW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic [3:0]    shift_req,
  input  logic          shift_we,
  input  logic          clr_overrun,
  output logic          sample,
  output logic          sr_val,
  output logic [3:0]    shift,
  output logic          busy,
  output logic          overrun,
  output logic [15:0]   frame_cnt
);

  localparam int WW = $clog2(DSR_LEN + 1);
  localparam logic [PW-1:0] CNT_ONE = PW'(1);
  localparam logic [WW-1:0] WORD_LAST = WW'(DSR_LEN - 1);

  typedef enum logic [2:0] {IDLE, WAIT, SNAP, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] cnt, cnt_step, reload;
  logic [WW-1:0] word, word_nxt;
  logic [3:0]    shadow;
  logic          expire, expire_next, last_word;

  // cnt==0 marks a period boundary; period=0 wraps to 2^PW-1, i.e. 2^PW cycles
  assign reload      = period - CNT_ONE;
  assign expire      = (cnt == '0);
  assign cnt_step    = expire ? reload : cnt - CNT_ONE;
  assign expire_next = (cnt_step == '0);
  assign last_word   = (word == WORD_LAST);

  assign sample = (state == SNAP);
  assign sr_val = (state == STREAM) || (state == DRAIN);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    case (state)
      IDLE: begin
        // a one-cycle period makes the very next cycle a boundary
        if (enable) state_nxt = (reload == '0) ? SNAP : WAIT;
      end
      WAIT: begin
        if (!enable)          state_nxt = IDLE;
        else if (expire_next) state_nxt = SNAP;
      end
      SNAP: begin
        state_nxt = STREAM;
        word_nxt  = '0;
      end
      STREAM, DRAIN: begin
        word_nxt = word + WW'(1);
        if (last_word) begin
          if (!enable)          state_nxt = IDLE;
          else if (expire_next) state_nxt = SNAP;
          else                  state_nxt = WAIT;
        end else if (expire) begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      shadow    <= '0;
      shift     <= '0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      // the period timer free-runs once started, even across a streaming frame
      if (state == IDLE) begin
        if (enable) cnt <= reload;
      end else begin
        cnt <= cnt_step;
      end
      if (shift_we) shadow <= shift_req;
      if (state == SNAP) shift <= shift_we ? shift_req : shadow;
      // an expiry while words are still streaming is dropped and flagged
      if (sr_val && expire)   overrun <= 1'b1;
      else if (clr_overrun)   overrun <= 1'b0;
      if (sr_val && last_word) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ccfilt_sequencer.sv
// Self-checking bench for ccfilt_sequencer: a timeline model predicts every
// output per cycle from the period, the enable window and the host strobes.
module tb_ccfilt_sequencer;

  localparam int L    = 12;
  localparam int PW   = 12;
  localparam int NMAX = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = PW'(20);
  logic [3:0]    shift_req = 4'd0;
  logic          shift_we = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          sample, sr_val, busy, overrun;
  logic [3:0]    shift;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int failures = 0;

  ccfilt_sequencer #(.DSR_LEN(L), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .shift_req(shift_req), .shift_we(shift_we), .clr_overrun(clr_overrun),
    .sample(sample), .sr_val(sr_val), .shift(shift), .busy(busy),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // per-cycle packed outputs: {sample, sr_val, busy, overrun, shift, frame_cnt}
  logic [23:0] act_v [NMAX];
  logic [23:0] exp_v [NMAX];
  bit          f_we  [NMAX];
  bit          f_clr [NMAX];
  logic [3:0]  f_req [NMAX];
  bit          r_we  [NMAX];
  bit          r_clr [NMAX];
  logic [3:0]  r_req [NMAX];
  int          run_len;

  // model state carried between runs
  logic [3:0]  m_shadow = 4'd0;
  logic [3:0]  m_shift  = 4'd0;
  logic        m_over   = 1'b0;
  logic [15:0] m_fcnt   = 16'd0;

  task automatic clear_stim();
    for (int t = 0; t < NMAX; t++) begin
      f_we[t] = 1'b0; f_clr[t] = 1'b0; f_req[t] = 4'd0;
    end
  endtask

  // Cycle 0 is the first cycle enable is high while idle; enable is high for t < d.
  task automatic run_timeline(input int p, input int d, input int we_pct, input int clr_pct);
    int samp[$];
    int b, pend, last_busy, n;
    bit is_s [NMAX];
    bit is_sr [NMAX];
    bit is_last [NMAX];
    logic [3:0]  shadow, sh;
    logic        ov;
    logic [15:0] fc;
    // frame schedule: a sample lands on a multiple of p that follows the previous
    // frame, and only if enable was still high the cycle before
    b = p; pend = 0;
    while (b - 1 < d) begin
      samp.push_back(b);
      pend = b + L;
      b = ((pend + p) / p) * p;
    end
    last_busy = (pend > d) ? pend : d;
    n = last_busy + 4;
    if (n > NMAX) n = NMAX;
    period = PW'(p);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      act_v[t] = {sample, sr_val, busy, overrun, shift, frame_cnt};
      enable = (t < d);
      r_we[t]  = f_we[t] || (int'($urandom_range(99)) < we_pct);
      r_req[t] = f_we[t] ? f_req[t] : 4'($urandom_range(15));
      r_clr[t] = f_clr[t] || (int'($urandom_range(99)) < clr_pct);
      shift_we = r_we[t]; shift_req = r_req[t]; clr_overrun = r_clr[t];
    end
    @(posedge clk); #1;
    shift_we = 1'b0; clr_overrun = 1'b0;
    for (int t = 0; t < NMAX; t++) begin
      is_s[t] = 1'b0; is_sr[t] = 1'b0; is_last[t] = 1'b0;
    end
    foreach (samp[i]) begin
      if (samp[i] < n) is_s[samp[i]] = 1'b1;
      for (int k = 1; k <= L; k++) if (samp[i] + k < n) is_sr[samp[i] + k] = 1'b1;
      if (samp[i] + L < n) is_last[samp[i] + L] = 1'b1;
    end
    shadow = m_shadow; sh = m_shift; ov = m_over; fc = m_fcnt;
    for (int t = 0; t < n; t++) begin
      exp_v[t] = {is_s[t], is_sr[t], (t >= 1 && t <= last_busy), ov, sh, fc};
      if (r_we[t]) shadow = r_req[t];
      if (is_s[t]) sh = shadow;
      if (is_sr[t] && (t % p == 0)) ov = 1'b1;
      else if (r_clr[t])            ov = 1'b0;
      if (is_last[t]) fc = fc + 16'd1;
    end
    m_shadow = shadow; m_shift = sh; m_over = ov; m_fcnt = fc;
    run_len = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; shift_we = 1'b1; shift_req = 4'hF; clr_overrun = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({sample, sr_val, busy, overrun, shift, frame_cnt} !== 24'h0) begin
        failures++;
        $display("FAIL reset_state got=%h exp=000000",
                 {sample, sr_val, busy, overrun, shift, frame_cnt});
      end
    end
    enable = 1'b0; shift_we = 1'b0; shift_req = 4'd0;
    rst_n = 1'b1;
    m_shadow = 4'd0; m_shift = 4'd0; m_over = 1'b0; m_fcnt = 16'd0;
  endtask

  task automatic test_periodic();
    int pos[$];
    clear_stim();
    run_timeline(20, 75, 10, 0);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL periodic t=%0d got=%h exp=%h", t, act_v[t], exp_v[t]);
      end
    end
    for (int t = 0; t < run_len; t++) if (act_v[t][23]) pos.push_back(t);
    checks++;
    if (pos.size() != 3 || pos[0] != 20 || pos[1] != 40 || pos[2] != 60) begin
      failures++;
      $display("FAIL periodic_sample_times got_count=%0d exp=3 at 20,40,60", pos.size());
    end
  endtask

  task automatic test_shift_shadow();
    logic [3:0] v2;
    clear_stim();
    v2 = 4'($urandom_range(15));
    if (v2 == 4'd6) v2 = 4'd9;
    f_we[25] = 1'b1; f_req[25] = 4'd6;
    f_we[40] = 1'b1; f_req[40] = v2;
    run_timeline(20, 75, 0, 0);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL shift_shadow t=%0d got=%h exp=%h", t, act_v[t], exp_v[t]);
      end
    end
    for (int t = 1; t < run_len; t++) begin
      if (act_v[t][22] && act_v[t-1][22]) begin
        checks++;
        if (act_v[t][19:16] !== act_v[t-1][19:16]) begin
          failures++;
          $display("FAIL shift_stable t=%0d got=%0d exp=%0d", t, act_v[t][19:16], act_v[t-1][19:16]);
        end
      end
    end
    checks++;
    if (act_v[45][19:16] !== v2) begin
      failures++;
      $display("FAIL shift_at_snap got=%0d exp=%0d", act_v[45][19:16], v2);
    end
  endtask

  task automatic test_overrun();
    clear_stim();
    f_clr[20] = 1'b1;
    f_clr[32] = 1'b1;
    run_timeline(8, 45, 0, 0);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL overrun t=%0d got=%h exp=%h", t, act_v[t], exp_v[t]);
      end
    end
    checks++;
    if (act_v[17][20] !== 1'b1 || act_v[22][20] !== 1'b0 || act_v[33][20] !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flags got=%b%b%b exp=101", act_v[17][20], act_v[22][20], act_v[33][20]);
    end
    checks++;
    if (act_v[8][23] !== 1'b1 || act_v[24][23] !== 1'b1 || act_v[40][23] !== 1'b1 || act_v[16][23] !== 1'b0) begin
      failures++;
      $display("FAIL overrun_spacing got=%b%b%b%b exp=1110",
               act_v[8][23], act_v[24][23], act_v[40][23], act_v[16][23]);
    end
  endtask

  task automatic test_enable_drop();
    int p, nsr;
    clear_stim();
    p = 14 + int'($urandom_range(16));
    run_timeline(p, p + 4, 10, 5);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL enable_drop p=%0d t=%0d got=%h exp=%h", p, t, act_v[t], exp_v[t]);
      end
    end
    nsr = 0;
    for (int t = 0; t < run_len; t++) if (act_v[t][22]) nsr++;
    checks++;
    if (nsr != L || act_v[p + L][21] !== 1'b1 || act_v[p + L + 1][21] !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop_frame got_words=%0d exp=%0d", nsr, L);
    end
  endtask

  task automatic test_async_reset();
    period = PW'(15);
    for (int t = 0; t <= 21; t++) begin
      @(posedge clk); #1;
      enable = 1'b1;
      shift_we = (t == 0); shift_req = 4'd9;
    end
    checks++;
    if (sr_val !== 1'b1 || shift !== 4'd9) begin
      failures++;
      $display("FAIL pre_reset_stream got=%b/%0d exp=1/9", sr_val, shift);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sample, sr_val, busy, overrun, shift, frame_cnt} !== 24'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=000000", {sample, sr_val, busy, overrun, shift, frame_cnt});
    end
    shift_we = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    rst_n = 1'b1;
    m_shadow = 4'd0; m_shift = 4'd0; m_over = 1'b0; m_fcnt = 16'd0;
    clear_stim();
    run_timeline(15, 40, 0, 0);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL after_reset t=%0d got=%h exp=%h", t, act_v[t], exp_v[t]);
      end
    end
    checks++;
    if (act_v[15][23] !== 1'b1) begin
      failures++;
      $display("FAIL first_sample_after_reset got=%b exp=1", act_v[15][23]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    run_timeline(13, 50 + int'($urandom_range(20)), 10, 0);
    for (int t = 0; t < run_len; t++) begin
      checks++;
      if (act_v[t] !== exp_v[t]) begin
        failures++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t, act_v[t], exp_v[t]);
      end
    end
    for (int t = 26; t + 1 < run_len; t += 13) begin
      if (act_v[t][23]) begin
        checks++;
        if (act_v[t-1][22] !== 1'b1 || act_v[t][22] !== 1'b0 || act_v[t+1][22] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gap t=%0d got=%b%b%b exp=101", t, act_v[t-1][22], act_v[t][22], act_v[t+1][22]);
        end
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overrun got=%b exp=0", overrun);
    end
  endtask

  task automatic test_random();
    int p, d;
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      p = 1 + int'($urandom_range(39));
      d = 1 + int'($urandom_range(119));
      run_timeline(p, d, 15, 10);
      for (int t = 0; t < run_len; t++) begin
        checks++;
        if (act_v[t] !== exp_v[t]) begin
          failures++;
          $display("FAIL random p=%0d d=%0d t=%0d got=%h exp=%h", p, d, t, act_v[t], exp_v[t]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_shift_shadow();
    test_overrun();
    test_enable_drop();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
